// File: rtl/mdu_pkg.sv
// Shared definitions for the Z-side multiply/divide unit: op encodings,
// controller states, default operand width and a conditional-negate helper.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;
  // Widest value the helper handles; 2*WIDTH must not exceed this.
  localparam int unsigned MDU_MAX_W = 128;

  typedef enum logic [1:0] {
    MDU_MUL  = 2'b00,
    MDU_MULU = 2'b01,
    MDU_DIV  = 2'b10,
    MDU_DIVU = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

  // Two's-complement negate when neg is set. Callers zero-extend into
  // MDU_MAX_W and cast the result back to their own width, so the same
  // helper serves magnitude extraction and final sign correction.
  function automatic logic [MDU_MAX_W-1:0] mdu_cond_neg(
    input logic [MDU_MAX_W-1:0] v,
    input logic                 neg
  );
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit. Operand A comes from Y, operand B from the
// bus; results land in ZHI/ZLO. Fixed latency: accept edge + WIDTH CALC
// edges + one FIX edge.
// Optional feature macro: MDU_UNSIGNED_OPS_EN (op[0] selects unsigned ops;
// when undefined every op is treated as signed).
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] zhi,
  output logic [WIDTH-1:0] zlo,
  output logic             div_zero
);

  localparam int unsigned W2       = 2 * WIDTH;
  localparam int unsigned CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mdu_state_e       r_state;
  mdu_state_e       w_state_nxt;

  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_neg_lo;   // product sign (MUL) or quotient sign (DIV)
  logic             r_neg_hi;   // product sign (MUL) or remainder sign (DIV)
  logic             r_dz;
  logic [WIDTH-1:0] r_a_raw;
  logic [WIDTH-1:0] r_mcand;    // multiplicand (MUL) or divisor (DIV)
  logic [W2-1:0]    r_acc;      // MUL: {partial, multiplier}; DIV: {rem, quot}

  logic             w_is_div;
  logic             w_is_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  logic [WIDTH:0]   w_mul_sum;
  logic [W2-1:0]    w_mul_next;
  logic [WIDTH:0]   w_div_trial;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_rem;
  logic [W2-1:0]    w_div_next;

  logic [W2-1:0]    w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

`ifndef MDU_UNSIGNED_OPS_EN
  logic             w_unused_op0;
  assign w_unused_op0 = op[0];
`endif

  // Operand decode: effective signedness, operand signs and magnitudes.
  always_comb begin
    w_is_div    = op[1];
`ifdef MDU_UNSIGNED_OPS_EN
    w_is_signed = ~op[0];
    w_a_neg     = w_is_signed & a_in[WIDTH-1];
    w_b_neg     = w_is_signed & b_in[WIDTH-1];
`else
    w_is_signed = 1'b1;
    w_a_neg     = a_in[WIDTH-1];
    w_b_neg     = b_in[WIDTH-1];
`endif
    w_a_mag     = WIDTH'(mdu_cond_neg(MDU_MAX_W'(a_in), w_a_neg));
    w_b_mag     = WIDTH'(mdu_cond_neg(MDU_MAX_W'(b_in), w_b_neg));
  end

  // One CALC iteration for each op: shift-add multiply step and one
  // restoring-divide quotient bit.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[W2-1:WIDTH]} +
                  (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    w_mul_next  = {w_mul_sum, r_acc[WIDTH-1:1]};
    // {rem, next dividend bit} minus divisor; MSB set means "did not fit".
    w_div_trial = r_acc[W2-1:WIDTH-1] - {1'b0, r_mcand};
    w_div_ge    = ~w_div_trial[WIDTH];
    w_div_rem   = w_div_ge ? w_div_trial[WIDTH-1:0] : r_acc[W2-2:WIDTH-1];
    w_div_next  = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};
  end

  // Sign correction applied in FIX.
  always_comb begin
    w_prod = W2'(mdu_cond_neg(MDU_MAX_W'(r_acc), r_neg_lo));
    w_quo  = WIDTH'(mdu_cond_neg(MDU_MAX_W'(r_acc[WIDTH-1:0]), r_neg_lo));
    w_rem  = WIDTH'(mdu_cond_neg(MDU_MAX_W'(r_acc[W2-1:WIDTH]), r_neg_hi));
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Controller next-state: IDLE -> CALC for WIDTH cycles -> FIX -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = CALC;
      CALC:    if (r_cnt == CNT_LAST) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      zhi      <= '0;
      zlo      <= '0;
      div_zero <= 1'b0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dz     <= 1'b0;
      r_a_raw  <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            r_cnt    <= '0;
            r_is_div <= w_is_div;
            r_neg_lo <= w_a_neg ^ w_b_neg;
            r_neg_hi <= w_is_div ? w_a_neg : (w_a_neg ^ w_b_neg);
            r_dz     <= w_is_div && (b_in == '0);
            r_a_raw  <= a_in;
            r_mcand  <= w_is_div ? w_b_mag : w_a_mag;
            r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
          end
        end
        CALC: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 1'b1;
        end
        FIX: begin
          busy     <= 1'b0;
          done     <= 1'b1;
          div_zero <= r_dz;
          if (r_dz) begin
            zhi <= r_a_raw;
            zlo <= '1;
          end else if (r_is_div) begin
            zhi <= w_rem;
            zlo <= w_quo;
          end else begin
            zhi <= w_prod[W2-1:WIDTH];
            zlo <= w_prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32).
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic [31:0] zhi;
  logic [31:0] zlo;
  logic        div_zero;

  int n_tests = 0;
  int n_fail  = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .zhi      (zhi),
    .zlo      (zlo),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a request so it is sampled at the next rising edge.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op    = o;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count edges after the accept edge until done, bounded.
  task automatic wait_done(output int edges, output logic busy_ok);
    edges   = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (!done && !busy) busy_ok = 1'b0;
    end while (!done && edges < 100);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz);
    int   edges;
    logic bok;
    start_op(o, a, b);
    check({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
    wait_done(edges, bok);
    check({tag, "_latency"}, 64'(edges), 64'd33);
    check({tag, "_busy_held"}, 64'(bok), 64'd1);
    check({tag, "_busy_low_at_done"}, 64'(busy), 64'd0);
    check({tag, "_zhi"}, 64'(zhi), 64'(ehi));
    check({tag, "_zlo"}, 64'(zlo), 64'(elo));
    check({tag, "_div_zero"}, 64'(div_zero), 64'(edz));
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    check({tag, "_zlo_hold"}, 64'(zlo), 64'(elo));
  endtask

  initial begin
    int   edges;
    int   dones;
    logic bok;

    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_zhi", 64'(zhi), 64'd0);
    check("rst_zlo", 64'(zlo), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    reset = 1'b0;

    // -3 * 7 = -21
    run_op("mul_neg", MDU_MUL, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
`ifdef MDU_UNSIGNED_OPS_EN
    run_op("mulu_max", MDU_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
`else
    run_op("mulu_max", MDU_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
`endif
    // -7 / 2 -> q=-3, r=-1
    run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    // most negative / -1 wraps, no trap
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    // divide by zero, then a clean MUL clears the flag
    run_op("div_zero", MDU_DIV, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    run_op("mul_clr_dz", MDU_MUL, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0);

    // 5*5 with a second start mid-flight that must be ignored.
    start_op(MDU_MUL, 32'd5, 32'd5);
    edges = 0;
    dones = 0;
    do begin
      if (edges == 9) begin
        op = MDU_DIV; a_in = 32'd100; b_in = 32'd7; start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      edges++;
      if (done) dones++;
    end while (!done && edges < 100);
    check("ign_latency", 64'(edges), 64'd33);
    check("ign_dones", 64'(dones), 64'd1);
    check("ign_zlo", 64'(zlo), 64'd25);
    check("ign_zhi", 64'(zhi), 64'd0);

    // Start during the done cycle is accepted.
    op = MDU_MUL; a_in = 32'd4; b_in = 32'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("done_cyc_busy", 64'(busy), 64'd1);
    wait_done(edges, bok);
    check("done_cyc_latency", 64'(edges), 64'd33);
    check("done_cyc_zlo", 64'(zlo), 64'd16);

    // Reset during an in-flight DIVU discards it.
    start_op(MDU_DIVU, 32'hFFFF_FFFF, 32'h10);
    repeat (13) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_zhi", 64'(zhi), 64'd0);
    check("midrst_zlo", 64'(zlo), 64'd0);
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("midrst_no_done", 64'(dones), 64'd0);
`ifdef MDU_UNSIGNED_OPS_EN
    run_op("divu_reissue", MDU_DIVU, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 1'b0);
`else
    // Without unsigned ops this is -1 / 16 -> q=0, r=-1.
    run_op("divu_reissue", MDU_DIVU, 32'hFFFF_FFFF, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
